// File: rtl/fft_peak_detect.sv
// Streaming spectral peak detector: squared magnitude per bin, windowed running
// maximum, one report per frame with a frame-length error flag.
module fft_peak_detect #(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 16,
  parameter int FRAME_LEN = 1024,
  parameter int MIN_BIN   = 1,
  parameter int MAX_BIN   = 511,
  localparam int MAG_W    = 2*DATA_W+1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_re,
  input  logic signed [DATA_W-1:0] s_im,
  input  logic                     s_last,
  output logic                     peak_valid,
  output logic [IDX_W-1:0]         peak_idx,
  output logic [MAG_W-1:0]         peak_mag,
  output logic                     len_err,
  output logic                     busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN-1);
  localparam int SQ_W = 2*DATA_W;

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] bin_cnt;
  logic             cnt_sat;
  logic             ovf;

  logic                     v1, last1, err1;
  logic signed [DATA_W-1:0] re1, im1;
  logic [IDX_W-1:0]         idx1;

  logic                     v2, last2, err2;
  logic signed [SQ_W-1:0]   sq_re, sq_im;
  logic [IDX_W-1:0]         idx2;

  logic                     v3, last3, err3;
  logic [MAG_W-1:0]         mag3;
  logic [IDX_W-1:0]         idx3;

  logic [MAG_W-1:0]         max_mag, cand_mag;
  logic [IDX_W-1:0]         max_idx, cand_idx;
  logic                     take;

  logic                     res_v, res_err;
  logic [MAG_W-1:0]         res_mag;
  logic [IDX_W-1:0]         res_idx;

  logic signed [SQ_W-1:0]   re_x, im_x;
  logic                     drained;

  assign drained = !v1 && !v2 && !v3;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (s_valid) state_nxt = s_last ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (s_valid && s_last) state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        if (s_valid)      state_nxt = s_last ? ST_FLUSH : ST_RUN;
        else if (drained) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Once bin FRAME_LEN-1 has been consumed the counter sticks; anything
  // accepted after that makes the frame too long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt <= '0;
      cnt_sat <= 1'b0;
      ovf     <= 1'b0;
    end else if (s_valid) begin
      if (s_last) begin
        bin_cnt <= '0;
        cnt_sat <= 1'b0;
        ovf     <= 1'b0;
      end else if (bin_cnt == LAST_IDX) begin
        cnt_sat <= 1'b1;
        ovf     <= ovf | cnt_sat;
      end else begin
        bin_cnt <= bin_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; last1 <= 1'b0; err1 <= 1'b0;
      re1 <= '0; im1 <= '0; idx1 <= '0;
    end else begin
      v1 <= s_valid;
      if (s_valid) begin
        last1 <= s_last;
        err1  <= (bin_cnt != LAST_IDX) || cnt_sat || ovf;
        re1   <= s_re;
        im1   <= s_im;
        idx1  <= bin_cnt;
      end
    end
  end

  always_comb begin
    re_x = {{DATA_W{re1[DATA_W-1]}}, re1};
    im_x = {{DATA_W{im1[DATA_W-1]}}, im1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; last2 <= 1'b0; err2 <= 1'b0;
      sq_re <= '0; sq_im <= '0; idx2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        last2 <= last1;
        err2  <= err1;
        sq_re <= re_x * re_x;
        sq_im <= im_x * im_x;
        idx2  <= idx1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; last3 <= 1'b0; err3 <= 1'b0;
      mag3 <= '0; idx3 <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        last3 <= last2;
        err3  <= err2;
        mag3  <= {1'b0, sq_re} + {1'b0, sq_im};
        idx3  <= idx2;
      end
    end
  end

  always_comb begin
    take     = v3 && (int'(idx3) >= MIN_BIN) && (int'(idx3) <= MAX_BIN) &&
               (mag3 > max_mag);
    cand_mag = take ? mag3 : max_mag;
    cand_idx = take ? idx3 : max_idx;
  end

  // The frame result is staged here with the last bin folded in, so the
  // accumulator is already cleared when the next frame's first bin arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_mag <= '0; max_idx <= '0;
      res_v <= 1'b0; res_err <= 1'b0; res_mag <= '0; res_idx <= '0;
    end else begin
      res_v <= v3 && last3;
      if (v3) begin
        if (last3) begin
          res_mag <= cand_mag;
          res_idx <= cand_idx;
          res_err <= err3;
          max_mag <= '0;
          max_idx <= '0;
        end else begin
          max_mag <= cand_mag;
          max_idx <= cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_valid <= 1'b0;
      peak_idx   <= '0;
      peak_mag   <= '0;
      len_err    <= 1'b0;
    end else begin
      peak_valid <= res_v;
      if (res_v) begin
        peak_idx <= res_idx;
        peak_mag <= res_mag;
        len_err  <= res_err;
      end
    end
  end

endmodule
